// File: rtl/xadc_channel_classifier.sv
// xadc_channel_classifier: reads NUM_CH auxiliary XADC channels over the DRP once per
// end-of-sequence, averages each channel over 2^AVG_LOG2 sweeps and reports the averages plus
// the index of the highest channel.
// Optional feature macro: HYSTERESIS_EN (winner only changes when beaten by HYST_THRESH).
module xadc_channel_classifier #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SAMPLE_W     = 12,
  parameter int unsigned AVG_LOG2     = 2,
  parameter logic [6:0]  BASE_ADDR    = 7'h10,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned HYST_THRESH  = 8,
  localparam int unsigned CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       EOS,
  output logic [6:0]                 DADDR,
  output logic                       DEN,
  output logic                       DWE,
  output logic [15:0]                DI,
  input  logic                       DRDY,
  input  logic [15:0]                DO,
  output logic [NUM_CH*SAMPLE_W-1:0] measured,
  output logic [CH_W-1:0]            network_output,
  output logic                       result_valid,
  output logic                       drp_error
);

  localparam int unsigned AccW = SAMPLE_W + AVG_LOG2;
  localparam int unsigned SwW  = AVG_LOG2 + 1;
  localparam int unsigned TmoW = $clog2(DRDY_TIMEOUT + 1);
  localparam int unsigned CmpW = SAMPLE_W + 1;

  localparam logic [SwW-1:0]  Sweeps  = SwW'(1 << AVG_LOG2);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(DRDY_TIMEOUT - 1);
  localparam logic [CH_W-1:0] ChLast  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StWaitEos, StReq, StWaitRdy, StNext, StDecide} state_e;

  state_e              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_ch, w_ch_nxt;
  logic [TmoW-1:0]     r_tmo, w_tmo_nxt;
  logic [SwW-1:0]      r_sweep, w_sweep_nxt;
  logic [AccW-1:0]     r_acc [NUM_CH];
  logic [AccW-1:0]     w_acc_nxt [NUM_CH];
  logic [SAMPLE_W-1:0] r_samp [NUM_CH];
  logic [SAMPLE_W-1:0] w_samp_nxt [NUM_CH];
  logic [SAMPLE_W-1:0] r_meas [NUM_CH];
  logic [SAMPLE_W-1:0] w_meas_nxt [NUM_CH];
  logic [CH_W-1:0]     r_net, w_net_nxt;
  logic                r_err, w_err_nxt;

  logic [AccW-1:0]     w_acc_sum [NUM_CH];
  logic [SAMPLE_W-1:0] w_avg [NUM_CH];
  logic [CH_W-1:0]     w_best;
  logic [CH_W-1:0]     w_pick;

  if (SAMPLE_W < 16) begin : g_unused_do
    logic w_unused_do;
    assign w_unused_do = ^DO[15-SAMPLE_W:0];
  end

`ifndef HYSTERESIS_EN
  logic [CmpW-1:0] w_unused_hyst;
  assign w_unused_hyst = CmpW'(HYST_THRESH);
`endif

  // Totals and averages for the sweep being closed in NEXT, plus the winner to publish.
  always_comb begin
    w_best = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_acc_sum[i] = r_acc[i] + AccW'(r_samp[i]);
      w_avg[i]     = SAMPLE_W'(w_acc_sum[i] >> AVG_LOG2);
    end
    // Strict compare keeps the lowest index on ties.
    for (int i = 1; i < NUM_CH; i++) begin
      if (w_avg[i] > w_avg[w_best]) w_best = CH_W'(i);
    end
`ifdef HYSTERESIS_EN
    w_pick = ({1'b0, w_avg[w_best]} > ({1'b0, w_avg[r_net]} + CmpW'(HYST_THRESH))) ?
             w_best : r_net;
`else
    w_pick = w_best;
`endif
  end

  // Next-state logic: sweep sequencing, DRP timeout, accumulation and result capture.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_tmo_nxt   = r_tmo;
    w_sweep_nxt = r_sweep;
    w_acc_nxt   = r_acc;
    w_samp_nxt  = r_samp;
    w_meas_nxt  = r_meas;
    w_net_nxt   = r_net;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (enable) w_state_nxt = StWaitEos;
      end
      StWaitEos: begin
        if (!enable) begin
          w_state_nxt = StIdle;
          w_sweep_nxt = '0;
          for (int i = 0; i < NUM_CH; i++) w_acc_nxt[i] = '0;
        end else if (EOS) begin
          w_ch_nxt    = '0;
          w_state_nxt = StReq;
        end
      end
      StReq: begin
        w_tmo_nxt   = '0;
        w_state_nxt = StWaitRdy;
      end
      StWaitRdy: begin
        if (DRDY) begin
          w_samp_nxt[r_ch] = DO[15 -: SAMPLE_W];
          w_state_nxt      = StNext;
        end else if (r_tmo == TmoLast) begin
          // Samples only reach the accumulators once a sweep completes, so the partial
          // sweep is dropped simply by leaving.
          w_err_nxt   = 1'b1;
          w_state_nxt = StWaitEos;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      StNext: begin
        if (r_ch != ChLast) begin
          w_ch_nxt    = r_ch + 1'b1;
          w_state_nxt = StReq;
        end else begin
          w_acc_nxt   = w_acc_sum;
          w_sweep_nxt = r_sweep + 1'b1;
          if (w_sweep_nxt == Sweeps) begin
            // Registered on entry to DECIDE so results are valid alongside result_valid.
            w_meas_nxt  = w_avg;
            w_net_nxt   = w_pick;
            w_state_nxt = StDecide;
          end else begin
            w_state_nxt = StWaitEos;
          end
        end
      end
      StDecide: begin
        w_sweep_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) w_acc_nxt[i] = '0;
        w_state_nxt = StWaitEos;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_ch    <= '0;
      r_tmo   <= '0;
      r_sweep <= '0;
      r_net   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]  <= '0;
        r_samp[i] <= '0;
        r_meas[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_tmo   <= w_tmo_nxt;
      r_sweep <= w_sweep_nxt;
      r_net   <= w_net_nxt;
      r_err   <= w_err_nxt;
      r_acc   <= w_acc_nxt;
      r_samp  <= w_samp_nxt;
      r_meas  <= w_meas_nxt;
    end
  end

  // DRP request and result outputs decoded from the state and result registers.
  always_comb begin
    DEN            = (r_state == StReq);
    DADDR          = DEN ? (BASE_ADDR + 7'(r_ch)) : 7'h0;
    DWE            = 1'b0;
    DI             = '0;
    result_valid   = (r_state == StDecide);
    network_output = r_net;
    drp_error      = r_err;
    measured       = '0;
    for (int i = 0; i < NUM_CH; i++) measured[i*SAMPLE_W +: SAMPLE_W] = r_meas[i];
  end

endmodule

// File: tb/tb_xadc_channel_classifier.sv
// Bench for xadc_channel_classifier: table vectors, hand-written corner sequences and random
// sweeps checked against a sum-and-divide reference model. Honours HYSTERESIS_EN.
module tb_xadc_channel_classifier;

  localparam int NumCh      = 4;
  localparam int SampleW    = 12;
  localparam int AvgLog2    = 2;
  localparam int Sweeps     = 1 << AvgLog2;
  localparam int HystThresh = 8;

  logic                     clk, rst, enable, EOS, DRDY;
  logic [15:0]              DO;
  logic [6:0]               DADDR;
  logic                     DEN, DWE;
  logic [15:0]              DI;
  logic [NumCh*SampleW-1:0] measured;
  logic [1:0]               network_output;
  logic                     result_valid, drp_error;

  xadc_channel_classifier #(
    .NUM_CH(NumCh), .SAMPLE_W(SampleW), .AVG_LOG2(AvgLog2), .BASE_ADDR(7'h10),
    .DRDY_TIMEOUT(64), .HYST_THRESH(HystThresh)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .EOS(EOS), .DADDR(DADDR), .DEN(DEN), .DWE(DWE),
    .DI(DI), .DRDY(DRDY), .DO(DO), .measured(measured), .network_output(network_output),
    .result_valid(result_valid), .drp_error(drp_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int errors, checks;
  int cur_vals [NumCh];
  int lat, withhold_ch;
  int last_meas [NumCh];
  int last_win;

  // Reference model: running sums per channel over completed sweeps only.
  int sum_m [NumCh];
  int nsw_m, cur_win_m;
  int exp_meas_m [NumCh];

  typedef struct packed {
    logic [NumCh-1:0][11:0] v;
    logic [1:0]             win;
    logic [6:0]             l;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int meas_of(input int i);
    return int'(measured[i*SampleW +: SampleW]);
  endfunction

  function automatic void model_clear_sums();
    for (int i = 0; i < NumCh; i++) sum_m[i] = 0;
    nsw_m = 0;
  endfunction

  function automatic void model_clear_all();
    model_clear_sums();
    cur_win_m = 0;
    for (int i = 0; i < NumCh; i++) exp_meas_m[i] = 0;
  endfunction

  // Returns 1 when this completed sweep should produce a result.
  function automatic bit model_sweep();
    int best;
    nsw_m++;
    for (int i = 0; i < NumCh; i++) sum_m[i] += cur_vals[i];
    if (nsw_m < Sweeps) return 1'b0;
    for (int i = 0; i < NumCh; i++) exp_meas_m[i] = sum_m[i] / Sweeps;
    best = 0;
    for (int i = 1; i < NumCh; i++) if (exp_meas_m[i] > exp_meas_m[best]) best = i;
`ifdef HYSTERESIS_EN
    if (exp_meas_m[best] > exp_meas_m[cur_win_m] + HystThresh) cur_win_m = best;
`else
    cur_win_m = best;
`endif
    model_clear_sums();
    return 1'b1;
  endfunction

  // DRP slave: answers each DEN after 'lat' cycles unless the channel is withheld.
  int rsp_ch, rsp_l;
  initial begin
    DRDY = 1'b0;
    DO   = '0;
    forever begin
      @(negedge clk);
      if (DEN === 1'b1 && (int'(DADDR) - 16) != withhold_ch) begin
        rsp_ch = int'(DADDR) - 16;
        if (rsp_ch < 0 || rsp_ch >= NumCh) rsp_ch = 0;
        rsp_l = lat;
        repeat (rsp_l) @(negedge clk);
        DO   = 16'((cur_vals[rsp_ch] << 4) | int'($urandom_range(0, 15)));
        DRDY = 1'b1;
        @(negedge clk);
        DRDY = 1'b0;
        DO   = 16'($urandom);
      end
    end
  end

  // One EOS-triggered sweep observed over a bounded window.
  task automatic do_sweep(input int l, input int wh, input bit extra, input string tag);
    int  n_den, n_rv, win, exp_den;
    bit  exp_rv;
    n_den       = 0;
    n_rv        = 0;
    lat         = l;
    withhold_ch = wh;
    exp_rv      = (wh < 0) ? model_sweep() : 1'b0;
    exp_den     = (wh < 0) ? NumCh : wh + 1;
    win         = NumCh * (l + 3) + ((wh >= 0) ? 80 : 8);
    EOS = 1'b1;
    @(negedge clk);
    EOS = 1'b0;
    for (int c = 0; c < win; c++) begin
      if (DEN) begin
        chk({tag, "_daddr"}, int'(DADDR), 16 + n_den);
        n_den++;
      end
      if (result_valid) begin
        n_rv++;
        for (int i = 0; i < NumCh; i++) last_meas[i] = meas_of(i);
        last_win = int'(network_output);
      end
      EOS = extra && (c == 3);
      @(negedge clk);
    end
    EOS = 1'b0;
    withhold_ch = -1;
    chk({tag, "_den_count"}, n_den, exp_den);
    chk({tag, "_rv_count"}, n_rv, int'(exp_rv));
    if (exp_rv && n_rv == 1) begin
      for (int i = 0; i < NumCh; i++) chk({tag, "_meas"}, last_meas[i], exp_meas_m[i]);
      chk({tag, "_win"}, last_win, cur_win_m);
    end
  endtask

  task automatic set_vec(input int idx, input int a, input int b, input int c, input int d,
                         input int w, input int l);
    tbl[idx].v[0] = 12'(a);
    tbl[idx].v[1] = 12'(b);
    tbl[idx].v[2] = 12'(c);
    tbl[idx].v[3] = 12'(d);
    tbl[idx].win  = 2'(w);
    tbl[idx].l    = 7'(l);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < NumCh; i++) chk({tag, "_meas"}, meas_of(i), 0);
    chk({tag, "_net"}, int'(network_output), 0);
    chk({tag, "_rv"}, int'(result_valid), 0);
    chk({tag, "_err"}, int'(drp_error), 0);
    chk({tag, "_den"}, int'(DEN), 0);
  endtask

  initial begin
    int  n;
    bit  found;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    enable = 1'b0;
    EOS = 1'b0;
    lat = 1;
    withhold_ch = -1;
    last_win = -1;
    for (int i = 0; i < NumCh; i++) begin
      cur_vals[i]  = 0;
      last_meas[i] = -1;
    end
    model_clear_all();

    set_vec(0, 'h100, 'h7FF, 'h200, 'h050, 1, 1);
    set_vec(1, 'hABC, 'hABC, 'hABC, 'hABC, 0, 2);
    set_vec(2, 'hFFF, 'hFFF, 'h000, 'hFFF, 0, 3);
    set_vec(3, 'h000, 'h000, 'h000, 'h001, 3, 64);
    set_vec(4, 'h005, 'h800, 'h800, 'h7FF, 1, 5);

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_dwe", int'(DWE), 0);
    chk("reset_di", int'(DI), 0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors: identical sweeps so each average equals the sample
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NumCh; i++) begin
        cur_vals[i]  = int'(tbl[r].v[i]);
        last_meas[i] = -1;
      end
      for (int s = 0; s < Sweeps; s++) do_sweep(int'(tbl[r].l), -1, 1'b0, "tbl");
      for (int i = 0; i < NumCh; i++) chk("tbl_const_meas", last_meas[i], int'(tbl[r].v[i]));
`ifndef HYSTERESIS_EN
      chk("tbl_const_win", last_win, int'(tbl[r].win));
`endif
    end

    // Averaging over four sweeps with distinct samples on channel 0
    for (int s = 0; s < Sweeps; s++) begin
      cur_vals = '{(s + 1) * 100, 0, 0, 0};
      do_sweep(2, -1, 1'b0, "avg");
    end
    chk("avg_ch0", last_meas[0], 250);

    // DRDY timeout mid-averaging: partial sweep discarded, flag sticky
    chk("to_err_before", int'(drp_error), 0);
    cur_vals = '{7, 8, 9, 10};
    do_sweep(2, -1, 1'b0, "to_pre");
    do_sweep(2, -1, 1'b0, "to_pre");
    cur_vals = '{4000, 4000, 4000, 4000};
    do_sweep(1, 2, 1'b0, "to_abort");
    chk("to_err_set", int'(drp_error), 1);
    cur_vals = '{7, 8, 9, 10};
    do_sweep(1, -1, 1'b0, "to_post");
    do_sweep(1, -1, 1'b0, "to_post");
    chk("to_err_sticky", int'(drp_error), 1);

    // enable low clears partial averaging; results hold; EOS ignored while idle
    cur_vals = '{50, 60, 70, 80};
    do_sweep(1, -1, 1'b0, "dis_pre");
    do_sweep(1, -1, 1'b0, "dis_pre");
    enable = 1'b0;
    model_clear_sums();
    repeat (3) @(negedge clk);
    EOS = 1'b1;
    @(negedge clk);
    EOS = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (DEN || result_valid) n++;
      @(negedge clk);
    end
    chk("dis_quiet", n, 0);
    for (int i = 0; i < NumCh; i++) chk("dis_meas_hold", meas_of(i), exp_meas_m[i]);
    chk("dis_net_hold", int'(network_output), cur_win_m);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    cur_vals = '{90, 20, 30, 40};
    for (int s = 0; s < Sweeps; s++) do_sweep(1, -1, 1'b0, "dis_post");

    // Random sweeps, random latency, stray EOS pulses mid-sweep
    for (int s = 0; s < 60; s++) begin
      for (int i = 0; i < NumCh; i++)
        cur_vals[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2))
                                                  : int'($urandom_range(0, 4095));
      do_sweep(int'($urandom_range(1, 5)), -1, ($urandom_range(0, 3) == 0), "rnd");
    end

    // Reset during WAIT_RDY followed by a late DRDY
    cur_vals = '{300, 200, 100, 50};
    do_sweep(1, -1, 1'b0, "rst_pre");
    do_sweep(1, -1, 1'b0, "rst_pre");
    lat = 10;
    withhold_ch = -1;
    EOS = 1'b1;
    @(negedge clk);
    EOS = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      if (DEN && DADDR == 7'h12) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_ch2", int'(found), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear_all();
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (DEN || result_valid) n++;
      @(negedge clk);
    end
    chk("rst_quiet", n, 0);
    check_idle_outputs("rst_mid");
    enable = 1'b1;
    repeat (2) @(negedge clk);
    cur_vals = '{11, 400, 22, 33};
    for (int s = 0; s < Sweeps; s++) do_sweep(2, -1, 1'b0, "rst_post");

`ifdef HYSTERESIS_EN
    // Winner held within the margin, replaced once the margin is exceeded
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear_all();
    repeat (2) @(negedge clk);
    cur_vals = '{100, 0, 0, 105};
    for (int s = 0; s < Sweeps; s++) do_sweep(1, -1, 1'b0, "hyst_a");
    chk("hyst_hold", last_win, 0);
    cur_vals = '{100, 0, 0, 109};
    for (int s = 0; s < Sweeps; s++) do_sweep(1, -1, 1'b0, "hyst_b");
    chk("hyst_switch", last_win, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
